// File: rtl/cactus_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : cactus_scheduler_if
// Description : Obstacle bus between the cactus scheduler, the game core and
//               the renderer. Carries the four slot positions, the update
//               strobe, the current scroll speed and the run status.
// Revision    : 1.0 - initial release
// ============================================================================
interface cactus_scheduler_if;
    logic        game_over;
    logic [11:0] cactuses0;
    logic [11:0] cactuses1;
    logic [11:0] cactuses2;
    logic [11:0] cactuses3;
    logic        cactus_sync;
    logic [3:0]  speed;
    logic        running;

    // Scheduler side: owns the obstacle positions
    modport master (
        input  game_over,
        output cactuses0, cactuses1, cactuses2, cactuses3,
        output cactus_sync, speed, running
    );

    // Consumer side: game core / renderer
    modport slave (
        output game_over,
        input  cactuses0, cactuses1, cactuses2, cactuses3,
        input  cactus_sync, speed, running
    );
endinterface
`default_nettype wire

// File: rtl/cactus_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cactus_scheduler
// Description : Spawns cactuses at pseudo-random gaps into four slots, scrolls
//               them left at a speed that ramps with play, frees them at the
//               left edge, and freezes/clears the field on game over.
// Revision    : 1.0 - initial release
// ============================================================================
module cactus_scheduler #(
    parameter int          STEP_DIV      = 250000,
    parameter int          X_SPAWN       = 1200,
    parameter int          MIN_GAP       = 350,
    parameter int          SPEED_INIT    = 2,
    parameter int          SPEED_MAX     = 8,
    parameter int          SPEEDUP_EVERY = 8,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    cactus_scheduler_if.master bus
);
    localparam int               c_div_w      = $clog2(STEP_DIV);
    localparam int               c_cnt_w      = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(STEP_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SPEEDUP_EVERY - 1);
    localparam logic [11:0]      c_x_spawn    = 12'(X_SPAWN);
    localparam logic [11:0]      c_min_gap    = 12'(MIN_GAP);
    localparam logic [11:0]      c_dist_max   = 12'hFFF;
    localparam logic [3:0]       c_speed_init = 4'(SPEED_INIT);
    localparam logic [3:0]       c_speed_max  = 4'(SPEED_MAX);
    localparam logic [15:0]      c_seed       = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_OVER  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t               r_state_q,   w_state_d;
    logic [c_div_w-1:0]   r_div_q,     w_div_d;
    logic [11:0]          r_slot_q [4];
    logic [11:0]          w_slot_d [4];
    logic [11:0]          r_dist_q,    w_dist_d;
    logic [11:0]          r_gap_q,     w_gap_d;
    logic [c_cnt_w-1:0]   r_cnt_q,     w_cnt_d;
    logic [3:0]           r_speed_q,   w_speed_d;
    logic [15:0]          r_lfsr_q,    w_lfsr_d;
    logic                 r_sync_q,    w_sync_d;
    logic                 r_running_q, w_running_d;
    logic                 w_tick;
    logic                 w_spawn;
    logic [12:0]          w_dist_sum;

    // Sequencer and step datapath: state transitions, divider, move/spawn/speed-up
    always_comb begin
        w_state_d  = r_state_q;
        w_div_d    = r_div_q;
        w_slot_d   = r_slot_q;
        w_dist_d   = r_dist_q;
        w_gap_d    = r_gap_q;
        w_cnt_d    = r_cnt_q;
        w_speed_d  = r_speed_q;
        w_sync_d   = 1'b0;
        w_spawn    = 1'b0;
        w_tick     = (r_state_q == ST_RUN) && (r_div_q == c_div_last);
        w_dist_sum = {1'b0, r_dist_q} + {9'd0, r_speed_q};
        // Fibonacci taps 16,14,13,11 seen from the MSB side of a left shift
        w_lfsr_d   = {r_lfsr_q[14:0], r_lfsr_q[15] ^ r_lfsr_q[13] ^ r_lfsr_q[12] ^ r_lfsr_q[10]};

        case (r_state_q)
            ST_IDLE: begin
                if (!bus.game_over) begin
                    w_state_d = ST_RUN;
                    w_div_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.game_over) begin
                    // Game over wins over a coincident tick: no movement
                    w_state_d = ST_OVER;
                end else begin
                    w_div_d = w_tick ? '0 : r_div_q + 1'b1;
                    if (w_tick) begin
                        // Move; anything that would cross the edge is freed
                        for (int i = 0; i < 4; i++) begin
                            if (r_slot_q[i] > {8'd0, r_speed_q}) begin
                                w_slot_d[i] = r_slot_q[i] - {8'd0, r_speed_q};
                            end else begin
                                w_slot_d[i] = 12'd0;
                            end
                        end
                        w_dist_d = w_dist_sum[12] ? c_dist_max : w_dist_sum[11:0];
                        // Spawn into the lowest free slot; stays pending if none
                        if (w_dist_d >= r_gap_q) begin
                            for (int i = 0; i < 4; i++) begin
                                if (!w_spawn && (w_slot_d[i] == 12'd0)) begin
                                    w_slot_d[i] = c_x_spawn;
                                    w_spawn     = 1'b1;
                                end
                            end
                        end
                        if (w_spawn) begin
                            w_dist_d = 12'd0;
                            w_gap_d  = c_min_gap + {3'b000, r_lfsr_q[7:0], 1'b0};
                            if (r_cnt_q == c_cnt_last) begin
                                w_cnt_d   = '0;
                                w_speed_d = (r_speed_q < c_speed_max) ? r_speed_q + 4'd1 : c_speed_max;
                            end else begin
                                w_cnt_d = r_cnt_q + 1'b1;
                            end
                        end
                        for (int i = 0; i < 4; i++) begin
                            if (w_slot_d[i] != r_slot_q[i]) begin
                                w_sync_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_OVER: begin
                if (!bus.game_over) begin
                    w_state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < 4; i++) begin
                    w_slot_d[i] = 12'd0;
                end
                w_speed_d = c_speed_init;
                w_cnt_d   = '0;
                w_dist_d  = c_dist_max;
                w_sync_d  = 1'b1;
                w_state_d = ST_RUN;
                w_div_d   = '0;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_running_d = (w_state_d == ST_RUN);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_div_q     <= '0;
            r_slot_q    <= '{default: 12'd0};
            r_dist_q    <= c_dist_max;
            r_gap_q     <= c_min_gap;
            r_cnt_q     <= '0;
            r_speed_q   <= c_speed_init;
            r_lfsr_q    <= c_seed;
            r_sync_q    <= 1'b0;
            r_running_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_div_q     <= w_div_d;
            r_slot_q    <= w_slot_d;
            r_dist_q    <= w_dist_d;
            r_gap_q     <= w_gap_d;
            r_cnt_q     <= w_cnt_d;
            r_speed_q   <= w_speed_d;
            r_lfsr_q    <= w_lfsr_d;
            r_sync_q    <= w_sync_d;
            r_running_q <= w_running_d;
        end
    end

    assign bus.cactuses0   = r_slot_q[0];
    assign bus.cactuses1   = r_slot_q[1];
    assign bus.cactuses2   = r_slot_q[2];
    assign bus.cactuses3   = r_slot_q[3];
    assign bus.cactus_sync = r_sync_q;
    assign bus.speed       = r_speed_q;
    assign bus.running     = r_running_q;
endmodule
`default_nettype wire
